rc_channel_decode: RTL and testbench
====================================

RC_CHANNEL_DECODE -- requirements
Module: rc_channel_decode

Interface
REQ-001 Parameter CNT_W, default 17: width of the raw pulse length (1 us units).
REQ-002 Parameter CENTER, default 1500: neutral pulse length.
REQ-003 Parameter MIN_LEN / MAX_LEN, default 900 / 2100: valid pulse range, inclusive.
REQ-004 Parameter DEADBAND, default 10: absolute offset below which the output is zero.
REQ-005 Parameter LIMIT, default 511: output clamp magnitude.
REQ-006 Parameter ACQ_COUNT, default 3: consecutive good pulses required to lock.
REQ-007 Parameter TIMEOUT, default 2500000: clk cycles without a good pulse before failsafe (50 ms at 50 MHz).
REQ-008 clk  in  1  single clock; all logic on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 pulse_length  in  CNT_W  measured width from the upstream pulse measurer.
REQ-011 pulse_ready  in  1  upstream measurement valid (low after counter overflow).
REQ-012 pulse_stb  in  1  one-cycle strobe marking a new measurement or an overflow.
REQ-013 value  out  10  signed, two's-complement channel position, range -LIMIT..+LIMIT.
REQ-014 value_stb  out  1  one-cycle pulse on every update of value.
REQ-015 failsafe  out  1  high whenever the FSM is not in LOCKED.

Function
REQ-016 good = pulse_stb & pulse_ready & MIN_LEN<=pulse_length<=MAX_LEN; bad = pulse_stb & ~good; both SHALL be registered with the shaped sample (stage S1, cycle N+1 for a strobe in cycle N).
REQ-017 Shaping at S1: d = pulse_length - CENTER, signed, CNT_W+1 bits; |d|<DEADBAND -> 0; d>LIMIT -> +LIMIT; d<-LIMIT -> -LIMIT; else d truncated to 10 bits.
REQ-018 FSM states NOSIG, ACQ, LOCKED; reset state is NOSIG.
REQ-019 NOSIG: S1 good -> ACQ with acq_cnt=1; when ACQ_COUNT=1, LOCKED instead.
REQ-020 ACQ: S1 good -> acq_cnt+1, then LOCKED once acq_cnt reaches ACQ_COUNT; S1 bad or timeout -> NOSIG with acq_cnt=0.
REQ-021 LOCKED: S1 good clears bad_cnt; S1 bad increments bad_cnt with value held; third consecutive bad or timeout -> NOSIG.
REQ-022 Averaging: 4-entry history of shaped samples; value = (sum of 4) >>> 2, arithmetic shift (floor), 12-bit signed sum.
REQ-023 On the transition into LOCKED, all 4 history entries SHALL be loaded with the locking sample so the output does not ramp.
REQ-024 In LOCKED, each S1 good sample SHALL push into the history, with value and value_stb updated at cycle N+2.
REQ-025 value_stb SHALL NOT pulse in NOSIG or ACQ, except as required by REQ-026.
REQ-026 On any transition LOCKED -> NOSIG, value SHALL become 0, history SHALL be cleared, and value_stb SHALL pulse once in the same cycle.
REQ-027 Timeout counter clears on S1 good, otherwise increments and saturates at TIMEOUT; timeout is asserted while counter == TIMEOUT.
REQ-028 If an S1 good sample and a timeout occur in the same cycle, the sample wins: counter clears and no transition to NOSIG occurs.
REQ-029 pulse_stb in back-to-back cycles SHALL each be processed; no input is dropped.

Reset
REQ-030 reset SHALL override all other events in the same cycle.
REQ-031 On reset: state NOSIG, value=0, value_stb=0, failsafe=1, history, acq_cnt, bad_cnt, timeout counter and S1 registers all 0.
REQ-032 reset asserted mid-pipeline SHALL discard any sample in S1; no value_stb follows reset.

Structure
REQ-033 Shared package/header rc_pkg SHALL hold CENTER, MIN_LEN, MAX_LEN, DEADBAND, LIMIT and the FSM state encodings.
REQ-034 The S1 shaping stage SHALL be the sub-module rc_sample_shape (registered range check, deadband, clamp); the FSM and averaging remain in the top.

Verification
REQ-035 Reset, then three strobes with length 1700, ready=1 -> failsafe falls at the third sample's N+2; value=200 with one value_stb.
REQ-036 Locked at 1500, then length 1505 -> value 0; length 2100 -> history {511,0,0,0} -> value 127.
REQ-037 Locked, then three strobes with ready=0 -> value held for the first two; after the third, value=0, value_stb pulses once, failsafe=1.
REQ-038 Locked, no strobes for TIMEOUT cycles -> failsafe=1, value=0; a good strobe in the timeout cycle -> remains LOCKED.
REQ-039 ACQ after two good samples, then length 800 -> NOSIG, failsafe stays 1, no value_stb.
REQ-040 reset asserted the cycle after a good strobe in LOCKED -> no value_stb, value=0, failsafe=1.

Source files
------------

// File: rtl/rc_pkg.sv
// Shared constants, FSM state encoding and the averaging helper for the RC channel decoder.
package rc_pkg;

  localparam int CENTER   = 1500;
  localparam int MIN_LEN  = 900;
  localparam int MAX_LEN  = 2100;
  localparam int DEADBAND = 10;
  localparam int LIMIT    = 511;

  localparam int VAL_W = 10;
  localparam int SUM_W = 12;

  typedef enum logic [1:0] {
    ST_NOSIG  = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } rc_state_t;

  // Floor of the mean of four samples; arithmetic shift rounds toward minus infinity.
  function automatic logic signed [VAL_W-1:0] avg4(
    input logic signed [VAL_W-1:0] a,
    input logic signed [VAL_W-1:0] b,
    input logic signed [VAL_W-1:0] c,
    input logic signed [VAL_W-1:0] d
  );
    logic signed [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d);
    sum = sum >>> 2;
    return sum[VAL_W-1:0];
  endfunction

endpackage

// File: rtl/rc_channel_decode_if.sv
// Pulse-measurement input and decoded-channel output bundle.
interface rc_channel_decode_if #(
  parameter int CNT_W = 17
);
  logic [CNT_W-1:0]   pulse_length;
  logic               pulse_ready;
  logic               pulse_stb;
  logic signed [9:0]  value;
  logic               value_stb;
  logic               failsafe;

  modport master (
    output pulse_length, pulse_ready, pulse_stb,
    input  value, value_stb, failsafe
  );

  modport slave (
    input  pulse_length, pulse_ready, pulse_stb,
    output value, value_stb, failsafe
  );
endinterface

// File: rtl/rc_sample_shape.sv
// S1 stage: registers the range check together with the deadbanded, clamped offset from center.
module rc_sample_shape #(
  parameter int CNT_W    = 17,
  parameter int CENTER   = rc_pkg::CENTER,
  parameter int MIN_LEN  = rc_pkg::MIN_LEN,
  parameter int MAX_LEN  = rc_pkg::MAX_LEN,
  parameter int DEADBAND = rc_pkg::DEADBAND,
  parameter int LIMIT    = rc_pkg::LIMIT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CNT_W-1:0]               pulse_length,
  input  logic                           pulse_ready,
  input  logic                           pulse_stb,
  output logic                           good,
  output logic                           bad,
  output logic signed [rc_pkg::VAL_W-1:0] sample
);
  import rc_pkg::*;

  localparam int D_W = CNT_W + 1;
  localparam logic signed [D_W-1:0] CENTER_D = D_W'(CENTER);
  localparam logic signed [D_W-1:0] DB_P     = D_W'(DEADBAND);
  localparam logic signed [D_W-1:0] DB_N     = D_W'(-DEADBAND);
  localparam logic signed [D_W-1:0] LIM_P    = D_W'(LIMIT);
  localparam logic signed [D_W-1:0] LIM_N    = D_W'(-LIMIT);
  localparam logic [CNT_W-1:0]      MIN_L    = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0]      MAX_L    = CNT_W'(MAX_LEN);

  logic signed [D_W-1:0]   d;
  logic                    in_range;
  logic signed [VAL_W-1:0] shaped;

  always_comb begin
    d        = $signed({1'b0, pulse_length}) - CENTER_D;
    in_range = (pulse_length >= MIN_L) && (pulse_length <= MAX_L);
    if (d > DB_N && d < DB_P)
      shaped = '0;
    else if (d > LIM_P)
      shaped = VAL_W'(LIMIT);
    else if (d < LIM_N)
      shaped = VAL_W'(-LIMIT);
    else
      shaped = d[VAL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      good   <= 1'b0;
      bad    <= 1'b0;
      sample <= '0;
    end else begin
      good   <= pulse_stb & pulse_ready & in_range;
      bad    <= pulse_stb & ~(pulse_ready & in_range);
      sample <= shaped;
    end
  end

endmodule

// File: rtl/rc_channel_decode.sv
// RC servo channel decoder: acquisition/lock FSM with failsafe and 4-sample output averaging.
module rc_channel_decode #(
  parameter int CNT_W     = 17,
  parameter int CENTER    = rc_pkg::CENTER,
  parameter int MIN_LEN   = rc_pkg::MIN_LEN,
  parameter int MAX_LEN   = rc_pkg::MAX_LEN,
  parameter int DEADBAND  = rc_pkg::DEADBAND,
  parameter int LIMIT     = rc_pkg::LIMIT,
  parameter int ACQ_COUNT = 3,
  parameter int TIMEOUT   = 2500000
) (
  input  logic                 clk,
  input  logic                 reset,
  rc_channel_decode_if.slave   bus
);
  import rc_pkg::*;

  // state     | meaning
  // ST_NOSIG  | no valid signal, failsafe asserted
  // ST_ACQ    | counting consecutive good pulses toward lock
  // ST_LOCKED | tracking; value updated per good pulse

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ACQ_W = $clog2(ACQ_COUNT + 1);

  rc_state_t               state;
  logic [ACQ_W-1:0]        acq_cnt;
  logic [1:0]              bad_cnt;
  logic [TMO_W-1:0]        tmo_cnt;
  logic                    timeout;
  logic                    lock_now;
  logic                    s1_good;
  logic                    s1_bad;
  logic signed [VAL_W-1:0] s1_sample;
  logic signed [VAL_W-1:0] hist [0:3];
  logic signed [VAL_W-1:0] value_r;
  logic                    value_stb_r;
  logic                    failsafe_r;

  rc_sample_shape #(
    .CNT_W   (CNT_W),
    .CENTER  (CENTER),
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN),
    .DEADBAND(DEADBAND),
    .LIMIT   (LIMIT)
  ) u_shape (
    .clk         (clk),
    .reset       (reset),
    .pulse_length(bus.pulse_length),
    .pulse_ready (bus.pulse_ready),
    .pulse_stb   (bus.pulse_stb),
    .good        (s1_good),
    .bad         (s1_bad),
    .sample      (s1_sample)
  );

  assign timeout  = (tmo_cnt == TMO_W'(TIMEOUT));
  assign lock_now = s1_good &&
                    (((state == ST_NOSIG) && (ACQ_COUNT == 1)) ||
                     ((state == ST_ACQ) && (acq_cnt + ACQ_W'(1) == ACQ_W'(ACQ_COUNT))));

  assign bus.value     = value_r;
  assign bus.value_stb = value_stb_r;
  assign bus.failsafe  = failsafe_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_NOSIG;
      acq_cnt     <= '0;
      bad_cnt     <= '0;
      tmo_cnt     <= '0;
      value_r     <= '0;
      value_stb_r <= 1'b0;
      failsafe_r  <= 1'b1;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else begin
      value_stb_r <= 1'b0;

      // A good sample beats a coincident timeout: the clear here and the FSM below both favour it.
      if (s1_good)
        tmo_cnt <= '0;
      else if (!timeout)
        tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (lock_now) begin
        state       <= ST_LOCKED;
        failsafe_r  <= 1'b0;
        acq_cnt     <= '0;
        bad_cnt     <= '0;
        for (int i = 0; i < 4; i++) hist[i] <= s1_sample;
        value_r     <= s1_sample;
        value_stb_r <= 1'b1;
      end else begin
        case (state)
          ST_NOSIG: begin
            if (s1_good) begin
              state   <= ST_ACQ;
              acq_cnt <= ACQ_W'(1);
            end
          end
          ST_ACQ: begin
            if (s1_good) begin
              acq_cnt <= acq_cnt + ACQ_W'(1);
            end else if (s1_bad || timeout) begin
              state   <= ST_NOSIG;
              acq_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (s1_good) begin
              bad_cnt     <= '0;
              hist[0]     <= s1_sample;
              hist[1]     <= hist[0];
              hist[2]     <= hist[1];
              hist[3]     <= hist[2];
              value_r     <= avg4(s1_sample, hist[0], hist[1], hist[2]);
              value_stb_r <= 1'b1;
            end else if ((s1_bad && bad_cnt == 2'd2) || timeout) begin
              state       <= ST_NOSIG;
              failsafe_r  <= 1'b1;
              bad_cnt     <= '0;
              for (int i = 0; i < 4; i++) hist[i] <= '0;
              value_r     <= '0;
              value_stb_r <= 1'b1;
            end else if (s1_bad) begin
              bad_cnt <= bad_cnt + 2'd1;
            end
          end
          default: begin
            state      <= ST_NOSIG;
            failsafe_r <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc_channel_decode.sv
// Randomized and directed bench for rc_channel_decode against an integer reference model.
module tb_rc_channel_decode;

  localparam int TMO = 200;
  localparam int ACQ = 3;

  localparam int M_NOSIG  = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCKED = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rc_channel_decode_if #(.CNT_W(17)) bus ();

  rc_channel_decode #(
    .CNT_W    (17),
    .ACQ_COUNT(ACQ),
    .TIMEOUT  (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: integer arithmetic straight from the decoder rules.
  int m_state = M_NOSIG;
  int m_acq = 0;
  int m_bad = 0;
  int m_since_good = 0;
  int m_hist[$] = '{0, 0, 0, 0};
  bit ev_good = 0;
  bit ev_bad = 0;
  int ev_s = 0;
  int e_val = 0;
  bit e_stb = 0;
  bit e_fs = 1;
  bit started = 0;
  int stb_cnt = 0;

  function automatic int shape(input int len);
    int d;
    d = len - 1500;
    if (d > -10 && d < 10) return 0;
    if (d > 511) return 511;
    if (d < -511) return -511;
    return d;
  endfunction

  function automatic int floor_div4(input int s);
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  function automatic int hist_avg();
    int s;
    s = 0;
    foreach (m_hist[i]) s += m_hist[i];
    return floor_div4(s);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_state = M_NOSIG; m_acq = 0; m_bad = 0; m_since_good = 0;
      m_hist = '{0, 0, 0, 0};
      ev_good = 0; ev_bad = 0; ev_s = 0;
      e_val = 0; e_stb = 0; e_fs = 1;
    end else begin
      bit tmo;
      int len;
      tmo = (m_since_good == TMO);
      e_stb = 0;
      if (ev_good) m_since_good = 0;
      else if (!tmo) m_since_good++;
      if (ev_good && ((m_state == M_NOSIG && ACQ == 1) || (m_state == M_ACQ && m_acq + 1 == ACQ))) begin
        m_state = M_LOCKED; m_acq = 0; m_bad = 0;
        m_hist = '{ev_s, ev_s, ev_s, ev_s};
        e_val = hist_avg(); e_stb = 1;
      end else if (m_state == M_NOSIG) begin
        if (ev_good) begin m_state = M_ACQ; m_acq = 1; end
      end else if (m_state == M_ACQ) begin
        if (ev_good) m_acq++;
        else if (ev_bad || tmo) begin m_state = M_NOSIG; m_acq = 0; end
      end else begin
        if (ev_good) begin
          m_bad = 0;
          m_hist.push_front(ev_s);
          void'(m_hist.pop_back());
          e_val = hist_avg(); e_stb = 1;
        end else if ((ev_bad && m_bad == 2) || tmo) begin
          m_state = M_NOSIG; m_bad = 0;
          m_hist = '{0, 0, 0, 0};
          e_val = 0; e_stb = 1;
        end else if (ev_bad) begin
          m_bad++;
        end
      end
      e_fs = (m_state != M_LOCKED);
      len = int'(bus.pulse_length);
      ev_good = bus.pulse_stb && bus.pulse_ready && len >= 900 && len <= 2100;
      ev_bad  = bus.pulse_stb && !ev_good;
      ev_s    = shape(len);
    end
  end

  // value_stb seen at this edge belongs to the previous cycle.
  always @(posedge clk) if (bus.value_stb) stb_cnt++;

  always @(negedge clk) begin
    if (started) begin
      check_val("value", int'(bus.value), e_val);
      check_val("value_stb", int'(bus.value_stb), int'(e_stb));
      check_val("failsafe", int'(bus.failsafe), int'(e_fs));
    end
  end

  task automatic strobe(input int len, input bit rdy);
    bus.pulse_length = 17'(len);
    bus.pulse_ready  = rdy;
    bus.pulse_stb    = 1'b1;
    @(negedge clk);
    bus.pulse_stb    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.pulse_length = '0;
    bus.pulse_ready  = 1'b0;
    bus.pulse_stb    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    started = 1;
    check_val("reset_value", int'(bus.value), 0);
    check_val("reset_failsafe", int'(bus.failsafe), 1);

    // Acquire at 1700
    stb_cnt = 0;
    strobe(1700, 1); idle(2);
    strobe(1700, 1); idle(2);
    strobe(1700, 1);
    check_val("acq_fs_before", int'(bus.failsafe), 1);
    idle(1);
    check_val("lock_value", int'(bus.value), 200);
    check_val("lock_failsafe", int'(bus.failsafe), 0);
    idle(3);
    check_val("lock_stb_count", stb_cnt, 1);

    // Deadband and clamp
    repeat (4) begin strobe(1500, 1); idle(1); end
    check_val("flush_value", int'(bus.value), 0);
    strobe(1505, 1); idle(2);
    check_val("deadband_value", int'(bus.value), 0);
    strobe(2100, 1); idle(2);
    check_val("clamp_avg_value", int'(bus.value), 127);

    // Three not-ready strobes drop lock
    idle(3);
    stb_cnt = 0;
    strobe(1600, 0); strobe(1600, 0); idle(2);
    check_val("bad_hold_value", int'(bus.value), 127);
    check_val("bad_hold_fs", int'(bus.failsafe), 0);
    strobe(1600, 0); idle(1);
    check_val("bad_drop_value", int'(bus.value), 0);
    check_val("bad_drop_fs", int'(bus.failsafe), 1);
    idle(3);
    check_val("bad_drop_stb_count", stb_cnt, 1);

    // Timeout drops lock
    strobe(1500, 1); strobe(1500, 1); strobe(1500, 1); idle(3);
    check_val("relock_fs", int'(bus.failsafe), 0);
    idle(TMO + 5);
    check_val("timeout_fs", int'(bus.failsafe), 1);
    check_val("timeout_value", int'(bus.value), 0);

    // Good sample in the timeout cycle keeps lock
    strobe(1500, 1); strobe(1500, 1); strobe(1500, 1);
    idle(TMO);
    strobe(1600, 1); idle(3);
    check_val("tie_fs", int'(bus.failsafe), 0);
    check_val("tie_value", int'(bus.value), 25);

    // ACQ aborted by an out-of-range pulse
    idle(TMO + 5);
    stb_cnt = 0;
    strobe(1700, 1); idle(1); strobe(1700, 1); idle(1);
    strobe(800, 1); idle(3);
    check_val("acq_abort_fs", int'(bus.failsafe), 1);
    check_val("acq_abort_stb_count", stb_cnt, 0);

    // Reset right behind a good strobe in LOCKED
    strobe(1700, 1); strobe(1700, 1); strobe(1700, 1); idle(3);
    check_val("pre_reset_fs", int'(bus.failsafe), 0);
    stb_cnt = 0;
    strobe(1800, 1);
    do_reset();
    idle(3);
    check_val("reset_mid_stb_count", stb_cnt, 0);
    check_val("reset_mid_value", int'(bus.value), 0);
    check_val("reset_mid_fs", int'(bus.failsafe), 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      int len;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        case ($urandom_range(0, 3))
          0: len = $urandom_range(800, 2200);
          1: len = $urandom_range(1485, 1515);
          2: begin
            int edges[4] = '{899, 900, 2100, 2101};
            len = edges[$urandom_range(0, 3)];
          end
          default: len = $urandom_range(1000, 2000);
        endcase
        strobe(len, $urandom_range(0, 9) != 0);
      end else if (r < 36) begin
        do_reset();
      end else if (r < 38) begin
        idle($urandom_range(TMO - 5, TMO + 20));
      end else begin
        idle(1);
      end
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
